// File: rtl/imageline_filter_stage.sv
// Streaming 3-tap horizontal RGB filter (bypass/blur/edge/invert); output registered one cycle after the next accept.
// Backpressure: In_ready drops while the output register is held or the last pixel flushes. Optional stats: IMAGELINE_FILTER_STATS_EN.
module imageline_filter_stage #(
    parameter int LINE_WIDTH = 640,
    parameter int CNT_W      = 10
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [31:0] Filter_config,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [29:0] In_data,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [29:0] Out_data,
    output logic        Out_eol
`ifdef IMAGELINE_FILTER_STATS_EN
    ,
    output logic [15:0] Line_count,
    output logic        Stall_seen
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_RUN, S_FLUSH} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cfg;
    logic [29:0]      win_l, win_c;
    logic [29:0]      tap_r;
    logic [29:0]      filt_px;
    logic             out_free, accept, emit, eol_nxt;
    logic             unused_cfg_bits;

    assign unused_cfg_bits = ^Filter_config[31:4];

    function automatic logic [9:0] filt_ch(input logic [3:0] c_cfg, input logic [9:0] l,
                                           input logic [9:0] c, input logic [9:0] r);
        logic [11:0] sum;
        logic [9:0]  diff;
        logic [12:0] shl;
        logic [9:0]  res;
        sum  = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 12'd2;
        diff = (r >= l) ? (r - l) : (l - r);
        shl  = {3'b000, diff} << c_cfg[3:2];
        case (c_cfg[1:0])
            2'd0:    res = c;
            2'd1:    res = 10'(sum >> 2);
            2'd2:    res = (shl > 13'd1023) ? 10'd1023 : shl[9:0];
            default: res = 10'd1023 - c;
        endcase
        return res;
    endfunction

    assign out_free = ~Out_valid | Out_ready;
    assign In_ready = out_free & (state != S_FLUSH);
    assign accept   = In_valid & In_ready;

    // win_l/win_c hold the left and centre of the pending window; the right tap is
    // the incoming pixel, or the centre itself when the line's last pixel is flushed.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        eol_nxt   = 1'b0;
        tap_r     = In_data;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_FIRST;
            end
            S_FIRST, S_RUN: begin
                if (accept) begin
                    emit      = 1'b1;
                    state_nxt = (cnt == LAST_IDX) ? S_FLUSH : S_RUN;
                end
            end
            S_FLUSH: begin
                tap_r = win_c;
                if (out_free) begin
                    emit      = 1'b1;
                    eol_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign filt_px = {filt_ch(cfg, win_l[29:20], win_c[29:20], tap_r[29:20]),
                      filt_ch(cfg, win_l[19:10], win_c[19:10], tap_r[19:10]),
                      filt_ch(cfg, win_l[9:0],   win_c[9:0],   tap_r[9:0])};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cfg       <= '0;
            win_l     <= '0;
            win_c     <= '0;
            Out_valid <= 1'b0;
            Out_data  <= '0;
            Out_eol   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (state == S_IDLE) begin
                    cfg   <= Filter_config[3:0];
                    win_l <= In_data;
                    win_c <= In_data;
                    cnt   <= CNT_W'(1);
                end else begin
                    win_l <= win_c;
                    win_c <= In_data;
                    cnt   <= cnt + CNT_W'(1);
                end
            end
            if (state == S_FLUSH && out_free) cnt <= '0;
            if (emit) begin
                Out_valid <= 1'b1;
                Out_data  <= filt_px;
                Out_eol   <= eol_nxt;
            end else if (Out_ready) begin
                Out_valid <= 1'b0;
            end
        end
    end

`ifdef IMAGELINE_FILTER_STATS_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Line_count <= '0;
            Stall_seen <= 1'b0;
        end else begin
            if (Out_valid && Out_ready && Out_eol) Line_count <= Line_count + 16'd1;
            if (Out_valid && !Out_ready) Stall_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imageline_filter_stage.sv
// Scoreboard bench for imageline_filter_stage with LINE_WIDTH=4.
`timescale 1ns/1ps
module tb_imageline_filter_stage;

    typedef logic [29:0] line_t [4];

    logic        Clock;
    logic        Resetn;
    logic [31:0] Filter_config;
    logic        In_valid;
    logic        In_ready;
    logic [29:0] In_data;
    logic        Out_valid;
    logic        Out_ready;
    logic [29:0] Out_data;
    logic        Out_eol;
`ifdef IMAGELINE_FILTER_STATS_EN
    logic [15:0] Line_count;
    logic        Stall_seen;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [30:0] exp_q[$];

    imageline_filter_stage #(.LINE_WIDTH(4), .CNT_W(3)) dut (
        .Clock(Clock), .Resetn(Resetn), .Filter_config(Filter_config),
        .In_valid(In_valid), .In_ready(In_ready), .In_data(In_data),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_data(Out_data),
        .Out_eol(Out_eol)
`ifdef IMAGELINE_FILTER_STATS_EN
        , .Line_count(Line_count), .Stall_seen(Stall_seen)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [9:0] m_ch(input int mode, input int sh, input int l, input int c, input int r);
        int v;
        case (mode)
            0: v = c;
            1: v = (l + 2 * c + r + 2) / 4;
            2: begin
                v = ((r > l) ? (r - l) : (l - r)) * (1 << sh);
                if (v > 1023) v = 1023;
            end
            default: v = 1023 - c;
        endcase
        return v[9:0];
    endfunction

    function automatic logic [29:0] model_px(input logic [3:0] c, input logic [29:0] l,
                                             input logic [29:0] m, input logic [29:0] r);
        logic [29:0] o;
        for (int ch = 0; ch < 3; ch++)
            o[ch*10 +: 10] = m_ch(int'(c[1:0]), int'(c[3:2]), int'(l[ch*10 +: 10]),
                                  int'(m[ch*10 +: 10]), int'(r[ch*10 +: 10]));
        return o;
    endfunction

    function automatic logic [29:0] rgb(input int v);
        return {v[9:0], v[9:0], v[9:0]};
    endfunction

    task automatic push_line(input logic [3:0] c, input line_t px);
        for (int i = 0; i < 4; i++) begin
            int li = (i == 0) ? 0 : i - 1;
            int ri = (i == 3) ? 3 : i + 1;
            exp_q.push_back({(i == 3), model_px(c, px[li], px[i], px[ri])});
        end
    endtask

    task automatic drive_pixel(input logic [29:0] p);
        bit ok = 0;
        In_valid = 1'b1;
        In_data  = p;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clock);
            if (In_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL in_accept_timeout pixel=%h In_ready never asserted", p);
        end else begin
            @(posedge Clock); #1;
        end
        In_valid = 1'b0;
    endtask

    task automatic drive_line(input line_t px);
        for (int i = 0; i < 4; i++) drive_pixel(px[i]);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge Clock);
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        @(posedge Clock); #1;
    endtask

    // Scoreboard: every consumed output is popped and compared.
    always @(negedge Clock) begin
        if (Resetn && Out_valid && Out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got eol=%b data=%h required none", Out_eol, Out_data);
            end else begin
                logic [30:0] e;
                e = exp_q.pop_front();
                if ({Out_eol, Out_data} !== e)
                    begin n_err++;
                    $display("FAIL out_pixel got eol=%b data=%h required eol=%b data=%h",
                             Out_eol, Out_data, e[30], e[29:0]); end
            end
        end
    end

    task automatic test_reset();
        Resetn = 1'b0; In_valid = 1'b0; In_data = '0; Out_ready = 1'b1; Filter_config = '0;
        #12;
        n_cmp++; if (Out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b required=0", Out_valid); end
        n_cmp++; if (Out_data !== 30'd0) begin n_err++; $display("FAIL reset_out_data got=%h required=0", Out_data); end
        n_cmp++; if (Out_eol !== 1'b0) begin n_err++; $display("FAIL reset_out_eol got=%b required=0", Out_eol); end
        n_cmp++; if (In_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b required=1", In_ready); end
`ifdef IMAGELINE_FILTER_STATS_EN
        n_cmp++; if (Line_count !== 16'd0) begin n_err++; $display("FAIL reset_line_count got=%0d required=0", Line_count); end
`endif
        @(negedge Clock); Resetn = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_bypass();
        line_t px = '{rgb(10), rgb(20), rgb(30), rgb(40)};
        Filter_config = 32'h0;
        push_line(4'h0, px);
        drive_line(px);
        // Last input just accepted: stage is flushing, pixel 2 in the output register.
        n_cmp++; if (In_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b required=0", In_ready); end
        n_cmp++; if (Out_eol !== 1'b0 || Out_data !== px[2]) begin n_err++;
            $display("FAIL pre_eol_pixel got eol=%b data=%h required eol=0 data=%h", Out_eol, Out_data, px[2]); end
        @(posedge Clock); #1;
        n_cmp++; if (Out_valid !== 1'b1 || Out_eol !== 1'b1 || Out_data !== px[3]) begin n_err++;
            $display("FAIL eol_latency got v=%b eol=%b data=%h required v=1 eol=1 data=%h",
                     Out_valid, Out_eol, Out_data, px[3]); end
        wait_drain();
`ifdef IMAGELINE_FILTER_STATS_EN
        n_cmp++; if (Stall_seen !== 1'b0) begin n_err++; $display("FAIL stall_seen_clear got=%b required=0", Stall_seen); end
        n_cmp++; if (Line_count !== 16'd1) begin n_err++; $display("FAIL line_count_one got=%0d required=1", Line_count); end
`endif
    endtask

    task automatic test_blur();
        line_t px = '{rgb(0), rgb(100), rgb(200), rgb(1023)};
        Filter_config = 32'hFFFF_FFF1;
        push_line(4'h1, px);
        drive_line(px);
        wait_drain();
    endtask

    task automatic test_edge();
        line_t px = '{rgb(0), rgb(0), rgb(300), rgb(300)};
        Filter_config = 32'h0000_000A;
        push_line(4'hA, px);
        drive_line(px);
        wait_drain();
    endtask

    task automatic test_backpressure();
        line_t px;
        logic [29:0] hold;
        px[0] = {10'd900, 10'd5, 10'd512};
        px[1] = {10'd100, 10'd1000, 10'd0};
        px[2] = {10'd1023, 10'd300, 10'd7};
        px[3] = {10'd40, 10'd40, 10'd800};
        Filter_config = 32'h1;
        push_line(4'h1, px);
        drive_pixel(px[0]);
        drive_pixel(px[1]);
        Out_ready = 1'b0;
        In_valid  = 1'b1;
        In_data   = px[2];
        hold = Out_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            n_cmp++; if (Out_valid !== 1'b1 || Out_data !== hold) begin n_err++;
                $display("FAIL stall_hold cyc=%0d got v=%b data=%h required v=1 data=%h", k, Out_valid, Out_data, hold); end
            n_cmp++; if (In_ready !== 1'b0) begin n_err++;
                $display("FAIL stall_in_ready cyc=%0d got=%b required=0", k, In_ready); end
        end
        @(posedge Clock); #1;
        Out_ready = 1'b1;
        drive_pixel(px[2]);
        drive_pixel(px[3]);
        wait_drain();
`ifdef IMAGELINE_FILTER_STATS_EN
        n_cmp++; if (Stall_seen !== 1'b1) begin n_err++; $display("FAIL stall_seen_set got=%b required=1", Stall_seen); end
`endif
    endtask

    task automatic test_config_change();
        line_t a = '{rgb(1), rgb(500), rgb(77), rgb(1000)};
        line_t b = '{rgb(3), rgb(600), rgb(0), rgb(1023)};
        Filter_config = 32'h0;
        push_line(4'h0, a);
        drive_pixel(a[0]);
        drive_pixel(a[1]);
        Filter_config = 32'h3;
        drive_pixel(a[2]);
        drive_pixel(a[3]);
        // Next line follows immediately, overlapping the eol pixel's consumption.
        push_line(4'h3, b);
        drive_line(b);
        wait_drain();
    endtask

    task automatic test_reset_midline();
        line_t px = '{rgb(8), rgb(16), rgb(24), rgb(1020)};
        Out_ready = 1'b0;
        Filter_config = 32'h0;
        drive_pixel(rgb(900));
        drive_pixel(rgb(901));
        Resetn = 1'b0;
        #1;
        n_cmp++; if (Out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid got=%b required=0", Out_valid); end
        n_cmp++; if (Out_eol !== 1'b0) begin n_err++; $display("FAIL midreset_out_eol got=%b required=0", Out_eol); end
`ifdef IMAGELINE_FILTER_STATS_EN
        n_cmp++; if (Line_count !== 16'd0) begin n_err++; $display("FAIL midreset_line_count got=%0d required=0", Line_count); end
`endif
        @(negedge Clock); Resetn = 1'b1; Out_ready = 1'b1;
        @(posedge Clock); #1;
        Filter_config = 32'h2;
        push_line(4'h2, px);
        drive_line(px);
        wait_drain();
`ifdef IMAGELINE_FILTER_STATS_EN
        n_cmp++; if (Line_count !== 16'd1) begin n_err++; $display("FAIL post_reset_line_count got=%0d required=1", Line_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_blur();
        test_edge();
        test_backpressure();
        test_config_change();
        test_reset_midline();
        repeat (5) @(posedge Clock);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_expected got=%0d required=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule
